// File: rtl/txaclbuf_arq_if.sv
// MCU bus-slave memory port of the ACL transmit buffer: word writes into
// the current write bank and commit of a filled bank with its byte length.
interface txaclbuf_arq_if #(
    parameter int AW = 5
) ();
    logic [2:0]    bsm_ch;
    logic [AW-1:0] bsm_addr;
    logic [31:0]   bsm_din;
    logic          bsm_we;
    logic          bsm_cs;
    logic          bsm_commit_p;
    logic [9:0]    bsm_len;

    modport master (
        output bsm_ch, bsm_addr, bsm_din, bsm_we, bsm_cs, bsm_commit_p, bsm_len
    );

    modport slave (
        input bsm_ch, bsm_addr, bsm_din, bsm_we, bsm_cs, bsm_commit_p, bsm_len
    );
endinterface

// File: rtl/txaclbuf_arq.sv
// Per-LT_ADDR ping-pong ACL transmit payload buffers with hardware ARQN/FLOW
// handling: bank released on ACK, retransmitted on NAK, held on FLOW=STOP.
// Optional macro TXBUF_FLUSH_EN adds regi_flush_p[NCH] to clear channels.
module txaclbuf_arq #(
    parameter int NCH   = 7,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic                 clk_6M,
    input  logic                 rstz,
    txaclbuf_arq_if.slave        bsm,
    input  logic [2:0]           ms_lt_addr,
    input  logic                 header_st_p,
    input  logic                 py_datperiod,
    input  logic [12:0]          pybitcount,
    input  logic                 rxhdr_p,
    input  logic [7:0]           dec_arqn,
    input  logic [7:0]           dec_flow,
`ifdef TXBUF_FLUSH_EN
    input  logic [NCH-1:0]       regi_flush_p,
`endif
    output logic                 lnctrl_txpybitin,
    output logic                 tx_bufvalid,
    output logic [9:0]           tx_pylenByte,
    output logic [NCH-1:0]       regi_txbufempty,
    output logic [NCH-1:0]       regi_txbuffull,
    output logic [NCH-1:0]       txdone_p,
    output logic                 overflow_p
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [31:0] mem [NCH][2][DEPTH];

    logic [NCH-1:0]           wr_q, wr_d, rd_q, rd_d;
    logic [NCH-1:0]           infl_q, infl_d, flow_q, flow_d;
    logic [NCH-1:0][1:0]      valid_q, valid_d;
    logic [NCH-1:0][1:0][9:0] len_q, len_d;
    logic                     tx_valid_d;
    logic [9:0]               tx_len_d;
    logic [CW-1:0]            tx_ch_q, tx_ch_d;
    logic [NCH-1:0]           done_d;
    logic                     ovf_d;
    logic [NCH-1:0]           flush;

    logic                     bsm_ok, ms_ok;
    logic [2:0]               bsm_m1, ms_m1;
    logic [CW-1:0]            bsm_idx, ms_idx;
    logic                     unused_flow0;

`ifdef TXBUF_FLUSH_EN
    assign flush = regi_flush_p;
`else
    assign flush = '0;
`endif

    // LT_ADDR 0 has no buffer; LT_ADDR n maps to channel n-1
    assign bsm_ok       = (bsm.bsm_ch != 3'd0) && (bsm.bsm_ch <= 3'(NCH));
    assign ms_ok        = (ms_lt_addr != 3'd0) && (ms_lt_addr <= 3'(NCH));
    assign bsm_m1       = bsm.bsm_ch - 3'd1;
    assign ms_m1        = ms_lt_addr - 3'd1;
    assign bsm_idx      = bsm_m1[CW-1:0];
    assign ms_idx       = ms_m1[CW-1:0];
    assign unused_flow0 = dec_flow[0];

    // Next-state for all channels: ARQ first, then source decision, then commit,
    // with flush overriding everything on its channel.
    always_comb begin
        logic go;
        logic hit_ms;
        logic hit_bsm;
        go         = 1'b0;
        hit_ms     = 1'b0;
        hit_bsm    = 1'b0;
        wr_d       = wr_q;
        rd_d       = rd_q;
        infl_d     = infl_q;
        flow_d     = flow_q;
        valid_d    = valid_q;
        len_d      = len_q;
        tx_valid_d = tx_bufvalid;
        tx_len_d   = tx_pylenByte;
        tx_ch_d    = tx_ch_q;
        done_d     = '0;
        ovf_d      = 1'b0;

        if (header_st_p && !ms_ok) begin
            tx_valid_d = 1'b0;
            tx_len_d   = '0;
        end

        for (int unsigned c = 0; c < NCH; c++) begin
            hit_ms  = ms_ok  && (ms_idx  == CW'(c));
            hit_bsm = bsm_ok && (bsm_idx == CW'(c));

            if (rxhdr_p) begin
                flow_d[c] = dec_flow[3'(c + 1)];
                if (hit_ms && infl_q[c]) begin
                    infl_d[c] = 1'b0;
                    if (dec_arqn[ms_lt_addr]) begin
                        valid_d[c][rd_q[c]] = 1'b0;
                        rd_d[c]             = ~rd_q[c];
                        done_d[c]           = 1'b1;
                    end
                end
            end

            // Decision sees the post-ARQ bank state but not a same-cycle commit
            if (header_st_p && hit_ms) begin
                go         = valid_d[c][rd_d[c]] && flow_d[c];
                infl_d[c]  = go;
                tx_valid_d = go;
                tx_len_d   = go ? len_q[c][rd_d[c]] : '0;
                tx_ch_d    = CW'(c);
            end

            if (bsm.bsm_commit_p && hit_bsm) begin
                if (valid_q[c][wr_q[c]]) begin
                    ovf_d = 1'b1;
                end else begin
                    valid_d[c][wr_q[c]] = 1'b1;
                    len_d[c][wr_q[c]]   = bsm.bsm_len;
                    wr_d[c]             = ~wr_q[c];
                end
            end

            if (flush[c]) begin
                valid_d[c] = '0;
                wr_d[c]    = 1'b0;
                rd_d[c]    = 1'b0;
                infl_d[c]  = 1'b0;
                done_d[c]  = 1'b0;
                if (tx_ch_d == CW'(c)) begin
                    tx_valid_d = 1'b0;
                end
            end
        end
    end

    // Channel state, source registers, status flags and event pulses
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            wr_q            <= '0;
            rd_q            <= '0;
            infl_q          <= '0;
            flow_q          <= '1;
            valid_q         <= '0;
            len_q           <= '0;
            tx_bufvalid     <= 1'b0;
            tx_pylenByte    <= '0;
            tx_ch_q         <= '0;
            txdone_p        <= '0;
            overflow_p      <= 1'b0;
            regi_txbufempty <= '1;
            regi_txbuffull  <= '0;
        end else begin
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            infl_q       <= infl_d;
            flow_q       <= flow_d;
            valid_q      <= valid_d;
            len_q        <= len_d;
            tx_bufvalid  <= tx_valid_d;
            tx_pylenByte <= tx_len_d;
            tx_ch_q      <= tx_ch_d;
            txdone_p     <= done_d;
            overflow_p   <= ovf_d;
            for (int unsigned c = 0; c < NCH; c++) begin
                regi_txbufempty[c] <= ~|valid_d[c];
                regi_txbuffull[c]  <= &valid_d[c];
            end
        end
    end

    // MCU writes land in the current write bank of the addressed channel
    always_ff @(posedge clk_6M) begin
        if (bsm.bsm_cs && bsm.bsm_we && bsm_ok) begin
            mem[bsm_idx][wr_q[bsm_idx]][bsm.bsm_addr] <= bsm.bsm_din;
        end
    end

    logic [7:0]  word_idx;
    logic        in_range;
    logic [31:0] rd_word;

    assign word_idx = pybitcount[12:5];
    assign in_range = ({1'b0, word_idx} < 9'(DEPTH));

    // Same-cycle payload word fetch from the read bank of the sourced channel
    always_comb begin
        rd_word = '0;
        if (in_range) begin
            rd_word = mem[tx_ch_q][rd_q[tx_ch_q]][word_idx[AW-1:0]];
        end
    end

    assign lnctrl_txpybitin = py_datperiod & tx_bufvalid & in_range & rd_word[pybitcount[4:0]];

endmodule

// File: tb/tb_txaclbuf_arq.sv
// Directed bench for txaclbuf_arq: stimulus pushes expected responses into
// queues, a monitor pops and compares when the DUT presents them.
module tb_txaclbuf_arq;
    localparam int NCH = 7;

    logic clk_6M = 1'b0;
    logic rstz;
    always #83 clk_6M = ~clk_6M;

    txaclbuf_arq_if #(.AW(5)) bsm_if ();

    logic [2:0]     ms_lt_addr;
    logic           header_st_p;
    logic           py_datperiod;
    logic [12:0]    pybitcount;
    logic           rxhdr_p;
    logic [7:0]     dec_arqn;
    logic [7:0]     dec_flow;
`ifdef TXBUF_FLUSH_EN
    logic [NCH-1:0] regi_flush_p;
`endif
    logic           lnctrl_txpybitin;
    logic           tx_bufvalid;
    logic [9:0]     tx_pylenByte;
    logic [NCH-1:0] regi_txbufempty;
    logic [NCH-1:0] regi_txbuffull;
    logic [NCH-1:0] txdone_p;
    logic           overflow_p;

    txaclbuf_arq #(.NCH(NCH), .DEPTH(32), .AW(5)) dut (
        .clk_6M           (clk_6M),
        .rstz             (rstz),
        .bsm              (bsm_if.slave),
        .ms_lt_addr       (ms_lt_addr),
        .header_st_p      (header_st_p),
        .py_datperiod     (py_datperiod),
        .pybitcount       (pybitcount),
        .rxhdr_p          (rxhdr_p),
        .dec_arqn         (dec_arqn),
        .dec_flow         (dec_flow),
`ifdef TXBUF_FLUSH_EN
        .regi_flush_p     (regi_flush_p),
`endif
        .lnctrl_txpybitin (lnctrl_txpybitin),
        .tx_bufvalid      (tx_bufvalid),
        .tx_pylenByte     (tx_pylenByte),
        .regi_txbufempty  (regi_txbufempty),
        .regi_txbuffull   (regi_txbuffull),
        .txdone_p         (txdone_p),
        .overflow_p       (overflow_p)
    );

    int errors = 0;
    int checks = 0;

    logic [10:0] hdr_q  [$];   // {tx_bufvalid, tx_pylenByte}
    logic [7:0]  evt_q  [$];   // {txdone_p, overflow_p}
    logic [13:0] flag_q [$];   // {regi_txbufempty, regi_txbuffull}
    logic        bit_q  [$];   // lnctrl_txpybitin
    logic        flag_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h with no expectation queued", name, act);
    endtask

    // Monitor: header decisions one edge after header_st_p, pulses whenever
    // seen, payload bits while py_datperiod is high, flags on request
    initial begin : monitor
        logic hp;
        forever begin
            @(posedge clk_6M);
            hp = header_st_p;
            @(negedge clk_6M);
            if (hp) begin
                if (hdr_q.size() == 0) unexpected("hdr", 32'({tx_bufvalid, tx_pylenByte}));
                else check("hdr", 32'({tx_bufvalid, tx_pylenByte}), 32'(hdr_q.pop_front()));
            end
            if (txdone_p != '0 || overflow_p) begin
                if (evt_q.size() == 0) unexpected("evt", 32'({txdone_p, overflow_p}));
                else check("evt", 32'({txdone_p, overflow_p}), 32'(evt_q.pop_front()));
            end
            if (py_datperiod) begin
                if (bit_q.size() == 0) unexpected("pybit", 32'(lnctrl_txpybitin));
                else check("pybit", 32'(lnctrl_txpybitin), 32'(bit_q.pop_front()));
            end
            if (flag_req) begin
                if (flag_q.size() == 0) unexpected("flags", 32'({regi_txbufempty, regi_txbuffull}));
                else check("flags", 32'({regi_txbufempty, regi_txbuffull}), 32'(flag_q.pop_front()));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk_6M);
        #1;
        header_st_p          = 1'b0;
        rxhdr_p              = 1'b0;
        bsm_if.bsm_commit_p  = 1'b0;
        bsm_if.bsm_cs        = 1'b0;
        bsm_if.bsm_we        = 1'b0;
        py_datperiod         = 1'b0;
        flag_req             = 1'b0;
`ifdef TXBUF_FLUSH_EN
        regi_flush_p         = '0;
`endif
    endtask

    task automatic write_word(input int lt, input int addr, input logic [31:0] data);
        bsm_if.bsm_ch   = 3'(lt);
        bsm_if.bsm_addr = 5'(addr);
        bsm_if.bsm_din  = data;
        bsm_if.bsm_cs   = 1'b1;
        bsm_if.bsm_we   = 1'b1;
        cyc();
    endtask

    task automatic commit(input int lt, input int len, input bit exp_ovf);
        bsm_if.bsm_ch       = 3'(lt);
        bsm_if.bsm_len      = 10'(len);
        bsm_if.bsm_commit_p = 1'b1;
        if (exp_ovf) evt_q.push_back(8'h01);
        cyc();
    endtask

    task automatic header(input int lt, input bit exp_v, input int exp_len);
        ms_lt_addr  = 3'(lt);
        header_st_p = 1'b1;
        hdr_q.push_back({exp_v, 10'(exp_len)});
        cyc();
    endtask

    task automatic rxhdr(input int lt, input bit arqn, input bit flow, input bit exp_done);
        ms_lt_addr    = 3'(lt);
        dec_arqn      = '0;
        dec_arqn[lt]  = arqn;
        dec_flow      = 8'hFF;
        dec_flow[lt]  = flow;
        rxhdr_p       = 1'b1;
        if (exp_done) evt_q.push_back({7'(1 << (lt - 1)), 1'b0});
        cyc();
    endtask

    task automatic flags(input logic [6:0] exp_empty, input logic [6:0] exp_full);
        flag_req = 1'b1;
        flag_q.push_back({exp_empty, exp_full});
        cyc();
    endtask

    task automatic pybit(input int idx, input bit exp);
        py_datperiod = 1'b1;
        pybitcount   = 13'(idx);
        bit_q.push_back(exp);
        cyc();
    endtask

    initial begin : stimulus
        rstz                = 1'b0;
        ms_lt_addr          = '0;
        header_st_p         = 1'b0;
        py_datperiod        = 1'b0;
        pybitcount          = '0;
        rxhdr_p             = 1'b0;
        dec_arqn            = '0;
        dec_flow            = 8'hFF;
        flag_req            = 1'b0;
        bsm_if.bsm_ch       = '0;
        bsm_if.bsm_addr     = '0;
        bsm_if.bsm_din      = '0;
        bsm_if.bsm_we       = 1'b0;
        bsm_if.bsm_cs       = 1'b0;
        bsm_if.bsm_commit_p = 1'b0;
        bsm_if.bsm_len      = '0;
`ifdef TXBUF_FLUSH_EN
        regi_flush_p        = '0;
`endif
        repeat (3) @(posedge clk_6M);
        #1;
        check("rst_bufvalid", 32'(tx_bufvalid), 32'h0);
        check("rst_pylen", 32'(tx_pylenByte), 32'h0);
        check("rst_empty", 32'(regi_txbufempty), 32'h7F);
        check("rst_full", 32'(regi_txbuffull), 32'h0);
        check("rst_done", 32'(txdone_p), 32'h0);
        check("rst_ovf", 32'(overflow_p), 32'h0);
        check("rst_pybit", 32'(lnctrl_txpybitin), 32'h0);
        rstz = 1'b1;
        cyc();

        // LT1: 5 words, 17 bytes, send and check serial bits
        for (int i = 0; i < 5; i++) write_word(1, i, 32'hA5A5_0001 + 32'(i));
        commit(1, 17, 1'b0);
        flags(7'h7E, 7'h00);
        header(1, 1'b1, 17);
        pybit(0, 1'b1);
        pybit(1, 1'b0);
        pybit(32, 1'b0);
        pybit(33, 1'b1);
        pybit(63, 1'b1);
        pybit(130, 1'b1);
        pybit(1024, 1'b0);

        // NAK: same bank retransmitted
        rxhdr(1, 1'b0, 1'b1, 1'b0);
        header(1, 1'b1, 17);
        pybit(32, 1'b0);
        pybit(33, 1'b1);

        // ACK: bank released
        rxhdr(1, 1'b1, 1'b1, 1'b1);
        flags(7'h7F, 7'h00);

        // FLOW=STOP holds the next bank, GO releases it
        write_word(1, 0, 32'h0000_0003);
        commit(1, 8, 1'b0);
        rxhdr(1, 1'b0, 1'b0, 1'b0);
        header(1, 1'b0, 0);
        pybit(0, 1'b0);
        flags(7'h7E, 7'h00);
        rxhdr(1, 1'b0, 1'b1, 1'b0);
        header(1, 1'b1, 8);
        pybit(0, 1'b1);
        pybit(1, 1'b1);
        pybit(2, 1'b0);
        rxhdr(1, 1'b1, 1'b1, 1'b1);
        flags(7'h7F, 7'h00);

        // LT0 has no buffer
        header(0, 1'b0, 0);
        commit(0, 3, 1'b0);
        flags(7'h7F, 7'h00);

        // LT2 overflow on third commit, bank 0 length kept
        commit(2, 40, 1'b0);
        commit(2, 41, 1'b0);
        flags(7'h7D, 7'h02);
        commit(2, 99, 1'b1);
        flags(7'h7D, 7'h02);
        header(2, 1'b1, 40);
        rxhdr(2, 1'b1, 1'b1, 1'b1);
        header(2, 1'b1, 41);
        rxhdr(2, 1'b1, 1'b1, 1'b1);
        flags(7'h7F, 7'h00);

        // LT3: commit and ACK release in the same cycle
        write_word(3, 0, 32'h0000_0001);
        commit(3, 5, 1'b0);
        header(3, 1'b1, 5);
        write_word(3, 0, 32'hFFFF_FFFF);
        bsm_if.bsm_ch       = 3'd3;
        bsm_if.bsm_len      = 10'd6;
        bsm_if.bsm_commit_p = 1'b1;
        ms_lt_addr          = 3'd3;
        dec_arqn            = 8'h08;
        dec_flow            = 8'hFF;
        rxhdr_p             = 1'b1;
        evt_q.push_back(8'h08);
        cyc();
        flags(7'h7B, 7'h00);
        header(3, 1'b1, 6);
        pybit(5, 1'b1);
`ifdef TXBUF_FLUSH_EN
        regi_flush_p = 7'h04;
        cyc();
        flags(7'h7F, 7'h00);
        pybit(5, 1'b0);
        header(3, 1'b0, 0);
`else
        rxhdr(3, 1'b1, 1'b1, 1'b1);
        flags(7'h7F, 7'h00);
`endif

        repeat (3) cyc();
        check("hdr_q_drained", 32'(hdr_q.size()), 32'h0);
        check("evt_q_drained", 32'(evt_q.size()), 32'h0);
        check("bit_q_drained", 32'(bit_q.size()), 32'h0);
        check("flag_q_drained", 32'(flag_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/txaclbuf_arq.md
Name: txaclbuf_arq

Overview:
Parametrised successor to the single ACL/SCO transmit buffer switch. Provides per-LT_ADDR ping-pong ACL transmit payload buffers with hardware ARQN/FLOW handling: automatic bank release on ACK, retransmission on NAK, and holding on FLOW=STOP. MCU buffer-switch commands are no longer needed. Sits between the MCU bus-slave memory port (bsm_*) and the link-controller payload serialiser.

Parameters:
NCH, 7, number of logical transports served; LT_ADDR 1..NCH map to channels 0..NCH-1, LT_ADDR 0 has no buffer
DEPTH, 32, 32-bit words per bank (power of 2, max 256)
AW, 5, word address width, equals log2(DEPTH)

Ports:
clk_6M  in  1  6 MHz system clock
rstz  in  1  asynchronous active-low reset
bsm_ch  in  3  MCU target LT_ADDR for write/commit
bsm_addr  in  AW  MCU word address within write bank
bsm_din  in  32  MCU write data
bsm_we  in  1  write strobe, qualified by bsm_cs
bsm_cs  in  1  MCU chip select
bsm_commit_p  in  1  pulse: mark current write bank of bsm_ch full
bsm_len  in  10  payload length in bytes, sampled with bsm_commit_p
ms_lt_addr  in  3  LT_ADDR of current TX/RX slot
header_st_p  in  1  pulse: TX header start; decides packet source
py_datperiod  in  1  TX payload bit period
pybitcount  in  13  TX payload bit index
rxhdr_p  in  1  pulse: received header HEC good; dec_arqn/dec_flow valid
dec_arqn  in  8  per-LT received ARQN
dec_flow  in  8  per-LT received FLOW
lnctrl_txpybitin  out  1  serial payload bit
tx_bufvalid  out  1  current packet is sourced from buffer; 0 means send NULL/POLL
tx_pylenByte  out  10  length of sourced packet
regi_txbufempty  out  NCH  both banks empty
regi_txbuffull  out  NCH  both banks full
txdone_p  out  NCH  pulse: bank released on ACK
overflow_p  out  1  pulse: commit rejected

Behaviour:
- Per-channel state: wr (1 bit), rd (1 bit), valid[1:0], len[1:0][9:0], inflight (1 bit). All zero at reset.
- Outputs at reset: regi_txbufempty all 1. Every other output 0.
- MCU write: when bsm_cs & bsm_we, write mem[ch][wr][bsm_addr] <= bsm_din. Writes to LT 0 or LT > NCH are ignored.
- Commit: on bsm_commit_p with valid[wr]==0, set valid[wr]<=1, len[wr]<=bsm_len, wr<=~wr. If valid[wr]==1, the commit is ignored and overflow_p is asserted for 1 cycle.
- Source decision, registered on header_st_p for ch=ms_lt_addr:
  - go = valid[rd] & flow_ok[ch].
  - tx_bufvalid<=go, inflight<=go, tx_pylenByte<=len[rd] if go, else 0.
  - flow_ok[ch] resets to 1 and updates on each rxhdr_p from dec_flow.
  - A STOP therefore holds the buffer and the link controller sends NULL.
- Payload read: the word at address pybitcount[12:5] of bank rd is selected while py_datperiod is high. Output bit = word[pybitcount[4:0]]. Output is 0 when word index >= DEPTH or tx_bufvalid==0. The path is combinational from pybitcount (same-cycle).
- ARQ, on rxhdr_p for ch=ms_lt_addr with inflight==1:
  - dec_arqn==1: valid[rd]<=0, rd<=~rd, inflight<=0, txdone_p[ch] for 1 cycle.
  - dec_arqn==0: inflight<=0 and bank kept, so the next header_st_p retransmits the identical payload.
- rxhdr_p while inflight==0: only flow_ok is updated.
- Simultaneous commit and ACK release on the same channel in the same cycle: both take effect. The empty/full flags reflect the combined result on the next cycle.
- Simultaneous header_st_p and rxhdr_p: ARQ update is applied first, then the source decision uses the post-update rd/valid.
- regi_txbufempty = ~|valid and regi_txbuffull = &valid, per channel, registered.
- Asynchronous reset mid-packet: all banks are emptied and tx_bufvalid drops immediately. Memory contents are don't-care.

Optional Feature:
TXBUF_FLUSH_EN: adds input regi_flush_p [NCH].
- A pulse clears valid, wr, rd and inflight of the selected channels in the next cycle, for LMP detach or link loss.
- Flush has priority over a commit or ACK in the same cycle.
- If the flushed channel is mid-payload, tx_bufvalid drops and the rest of the payload outputs 0.
- Without the macro, the port is absent and buffers are cleared only by ACK or reset.

Test Plan:
- Commit LT1 len=17 words 0xA5A5_0001.., header_st_p LT1 -> tx_bufvalid=1, tx_pylenByte=17, bit 0 of word 0 = 1, regi_txbufempty[0]=0.
- rxhdr_p LT1 arqn=1 after send -> txdone_p[0] 1 cycle, rd flips, regi_txbufempty[0]=1.
- rxhdr_p arqn=0 -> next header_st_p sends the same bank; pybitcount=32 returns word 1 again.
- rxhdr_p flow=0 then header_st_p -> tx_bufvalid=0, bank still valid. flow=1 then header_st_p -> sent.
- Three commits to LT2 without ACK -> third gives overflow_p=1, regi_txbuffull[1]=1, len of bank 0 unchanged.
- Commit and ACK release on LT3 in the same cycle -> one bank valid afterwards, no overflow. With TXBUF_FLUSH_EN: flush LT3 -> regi_txbufempty[2]=1 next cycle.
